// File: rtl/i2c_target_port.sv
// i2c_target_port: I2C target with 7-bit address match, byte write stream and byte read requests
module i2c_target_port #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_oe,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       wr_first,
  input  logic       wr_ready,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       stop
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP} state_t;
  state_t state;
  logic [1:0] scl_sync, sda_sync;
  logic scl_d, sda_d, scl, sda, scl_rise, scl_fall, start_det, stop_det;
  logic [6:0] shreg;
  logic [7:0] tx, byte_in;
  logic [2:0] cnt;
  logic rw, phase, first, wr_ok, rd_load;
  assign scl = scl_sync[1];
  assign sda = sda_sync[1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start_det = scl & scl_d & sda_d & ~sda;
  assign stop_det = scl & scl_d & ~sda_d & sda;
  assign byte_in = {shreg, sda};
  assign scl_o = 1'b1;
  assign scl_oe = 1'b0;
  assign sda_o = ~sda_oe;
  // Bus synchronizers plus one delayed copy for edge detection; idle bus is high
  always_ff @(posedge clk or posedge rst)
    if (rst) {scl_sync, sda_sync, scl_d, sda_d} <= '1;
    else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_d <= scl;
      sda_d <= sda;
    end
  // Protocol FSM; phase marks the second half of an ACK slot
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sda_oe <= 1'b0;
      wr_data <= '0;
      wr_valid <= 1'b0;
      wr_first <= 1'b0;
      rd_req <= 1'b0;
      busy <= 1'b0;
      stop <= 1'b0;
      shreg <= '0;
      tx <= '0;
      cnt <= '0;
      rw <= 1'b0;
      phase <= 1'b0;
      first <= 1'b0;
      wr_ok <= 1'b0;
      rd_load <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      wr_first <= 1'b0;
      rd_req <= 1'b0;
      stop <= 1'b0;
      rd_load <= rd_req;
      if (rd_load) tx <= rd_data;
      if (stop_det) begin
        state <= IDLE;
        sda_oe <= 1'b0;
        busy <= 1'b0;
        stop <= busy;
      end else if (start_det) begin
        state <= ADDR;
        cnt <= '0;
        sda_oe <= 1'b0;
        busy <= 1'b0;
        phase <= 1'b0;
      end else
        case (state)
          ADDR:
            if (scl_rise) begin
              shreg <= byte_in[6:0];
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                if (byte_in[7:1] == SLAVE_ADDR && byte_in[7:1] != 7'd0) begin
                  state <= ADDR_ACK;
                  busy <= 1'b1;
                  rw <= sda;
                  rd_req <= sda;
                  first <= 1'b1;
                  phase <= 1'b0;
                end else state <= WAIT_STOP;
              end
            end
          ADDR_ACK:
            if (scl_fall) begin
              phase <= ~phase;
              cnt <= '0;
              sda_oe <= phase ? (rw & ~tx[7]) : 1'b1;
              if (phase) state <= rw ? RD_DATA : WR_DATA;
            end
          WR_DATA:
            if (scl_rise) begin
              shreg <= byte_in[6:0];
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                wr_data <= byte_in;
                wr_valid <= 1'b1;
                wr_first <= first;
                first <= 1'b0;
                wr_ok <= wr_ready;
                phase <= 1'b0;
                state <= WR_ACK;
              end
            end
          WR_ACK:
            if (scl_fall) begin
              if (!wr_ok) begin
                sda_oe <= 1'b0;
                state <= WAIT_STOP;
              end else begin
                phase <= ~phase;
                sda_oe <= ~phase;
                cnt <= '0;
                if (phase) state <= WR_DATA;
              end
            end
          RD_DATA:
            if (scl_fall) begin
              cnt <= cnt + 3'd1;
              tx <= {tx[6:0], 1'b0};
              sda_oe <= (cnt == 3'd7) ? 1'b0 : ~tx[6];
              if (cnt == 3'd7) begin
                state <= RD_ACK;
                phase <= 1'b0;
              end
            end
          RD_ACK:
            if (scl_rise && !phase) begin
              if (sda) state <= WAIT_STOP;
              else begin
                rd_req <= 1'b1;
                phase <= 1'b1;
              end
            end else if (scl_fall && phase) begin
              sda_oe <= ~tx[7];
              cnt <= '0;
              state <= RD_DATA;
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_i2c_target_port.sv
// tb_i2c_target_port: bit-banged I2C master driving table vectors and read/reset sequences
module tb_i2c_target_port;
  localparam int Q = 100;
  typedef struct {
    logic [7:0] addr;
    logic [0:2][7:0] d;
    int n;
    logic ready;
    int acks;
    int wrs;
    int stops;
  } wvec_t;
  logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1, wr_ready = 1'b1;
  logic scl_o, scl_oe, sda_o, sda_oe, wr_valid, wr_first, rd_req, busy, stop, sda_line;
  logic [7:0] wr_data, rd_data, b;
  logic [7:0] rd_tab [16];
  logic [7:0] wr_log [32];
  logic wr_first_log [32];
  int wr_n = 0, stop_n = 0, rd_n = 0, oe_n = 0, busy_n = 0, bad_n = 0;
  int checks = 0, errors = 0;
  wvec_t vecs [6];
  assign sda_line = sda_m & ~sda_oe;
  assign rd_data = rd_tab[rd_n % 16];
  always #5 clk = ~clk;
  i2c_target_port #(.SLAVE_ADDR(7'h50)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .scl_o(scl_o), .scl_oe(scl_oe),
    .sda_i(sda_line), .sda_o(sda_o), .sda_oe(sda_oe), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_first(wr_first), .wr_ready(wr_ready), .rd_req(rd_req),
    .rd_data(rd_data), .busy(busy), .stop(stop)
  );
  always @(negedge clk) begin
    if (wr_valid) begin
      wr_log[wr_n % 32] = wr_data;
      wr_first_log[wr_n % 32] = wr_first;
      wr_n++;
    end
    if (stop) stop_n++;
    if (rd_req) rd_n++;
    if (sda_oe) oe_n++;
    if (busy) busy_n++;
    if (sda_o === sda_oe || scl_o !== 1'b1 || scl_oe !== 1'b0) bad_n++;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic clk_bit(input logic v, output logic s);
    #Q sda_m = v;
    #Q scl_m = 1'b1;
    #Q s = sda_line;
    #Q scl_m = 1'b0;
  endtask
  task automatic start_c();
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
  endtask
  task automatic stop_c();
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask
  task automatic send_byte(input logic [7:0] v, output int ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(v[i], s);
    clk_bit(1'b1, s);
    ack = int'(!s);
  endtask
  task automatic read_byte(input logic ack, output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      v[i] = s;
    end
    clk_bit(!ack, s);
  endtask
  initial begin
    int a, acks, w0, s0, o0, b0, r0;
    logic s;
    foreach (rd_tab[i]) rd_tab[i] = 8'h00;
    vecs[0] = '{8'hA0, {8'h01, 8'h23, 8'h5A}, 3, 1'b1, 4, 3, 1};
    vecs[1] = '{8'hA4, {8'h00, 8'h00, 8'h00}, 0, 1'b1, 0, 0, 0};
    vecs[2] = '{8'h00, {8'h11, 8'h00, 8'h00}, 1, 1'b1, 0, 0, 0};
    vecs[3] = '{8'hA0, {8'h77, 8'h88, 8'h00}, 2, 1'b0, 1, 1, 1};
    vecs[4] = '{8'hA0, {8'hFF, 8'h00, 8'h00}, 1, 1'b1, 2, 1, 1};
    vecs[5] = '{8'hA2, {8'h33, 8'h00, 8'h00}, 1, 1'b1, 0, 0, 0};
    #23;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_sda_o", sda_o, 1);
    chk("rst_scl", {scl_o, scl_oe}, 2'b10);
    chk("rst_pulses", {wr_valid, wr_first, rd_req, busy, stop}, 0);
    chk("rst_wr_data", wr_data, 0);
    #17 rst = 1'b0;
    #Q;
    for (int i = 0; i < 6; i++) begin
      w0 = wr_n; s0 = stop_n; o0 = oe_n; b0 = busy_n;
      wr_ready = vecs[i].ready;
      start_c();
      send_byte(vecs[i].addr, acks);
      for (int k = 0; k < vecs[i].n; k++) begin
        send_byte(vecs[i].d[k], a);
        acks += a;
      end
      stop_c();
      #(4 * Q);
      chk($sformatf("v%0d_acks", i), acks, vecs[i].acks);
      chk($sformatf("v%0d_wr_count", i), wr_n - w0, vecs[i].wrs);
      chk($sformatf("v%0d_stop_count", i), stop_n - s0, vecs[i].stops);
      chk($sformatf("v%0d_sda_pulled", i), int'(oe_n != o0), int'(vecs[i].acks != 0));
      chk($sformatf("v%0d_busy_seen", i), int'(busy_n != b0), int'(vecs[i].acks != 0));
      chk($sformatf("v%0d_busy_end", i), busy, 0);
      for (int k = 0; k < vecs[i].wrs; k++) begin
        chk($sformatf("v%0d_wr_data%0d", i, k), wr_log[(w0 + k) % 32], vecs[i].d[k]);
        chk($sformatf("v%0d_wr_first%0d", i, k), wr_first_log[(w0 + k) % 32], int'(k == 0));
      end
    end
    wr_ready = 1'b1;
    r0 = rd_n; s0 = stop_n;
    rd_tab[(rd_n + 1) % 16] = 8'hC3;
    start_c();
    send_byte(8'hA1, a);
    chk("rd1_addr_ack", a, 1);
    read_byte(1'b0, b);
    chk("rd1_byte", b, 8'hC3);
    #(2 * Q);
    chk("rd1_released", sda_oe, 0);
    chk("rd1_req_count", rd_n - r0, 1);
    stop_c();
    #(2 * Q);
    chk("rd1_stop", stop_n - s0, 1);
    r0 = rd_n; w0 = wr_n;
    rd_tab[(rd_n + 1) % 16] = 8'h5A;
    rd_tab[(rd_n + 2) % 16] = 8'h5B;
    start_c();
    send_byte(8'hA0, a);
    chk("rs_addr_ack", a, 1);
    send_byte(8'h10, a);
    chk("rs_data_ack", a, 1);
    start_c();
    chk("rs_busy_cleared", busy, 0);
    send_byte(8'hA1, a);
    chk("rs_raddr_ack", a, 1);
    read_byte(1'b1, b);
    chk("rs_byte0", b, 8'h5A);
    read_byte(1'b0, b);
    chk("rs_byte1", b, 8'h5B);
    stop_c();
    #(2 * Q);
    chk("rs_req_count", rd_n - r0, 2);
    chk("rs_wr_count", wr_n - w0, 1);
    chk("rs_wr_data", wr_log[w0 % 32], 8'h10);
    rd_tab[(rd_n + 1) % 16] = 8'h00;
    start_c();
    send_byte(8'hA1, a);
    chk("rr_addr_ack", a, 1);
    clk_bit(1'b1, s);
    clk_bit(1'b1, s);
    #Q sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #(Q / 2);
    chk("rr_driving", sda_oe, 1);
    s0 = stop_n;
    rst = 1'b1;
    #1;
    chk("rr_released", sda_oe, 0);
    chk("rr_sda_o", sda_o, 1);
    chk("rr_busy", busy, 0);
    #9 rst = 1'b0;
    #Q scl_m = 1'b0;
    stop_c();
    #(2 * Q);
    chk("rr_no_stop", stop_n - s0, 0);
    w0 = wr_n; s0 = stop_n;
    start_c();
    send_byte(8'hA0, a);
    chk("rr_w_addr_ack", a, 1);
    send_byte(8'h42, a);
    chk("rr_w_data_ack", a, 1);
    stop_c();
    #(2 * Q);
    chk("rr_w_count", wr_n - w0, 1);
    chk("rr_w_data", wr_log[w0 % 32], 8'h42);
    chk("rr_w_first", wr_first_log[w0 % 32], 1);
    chk("rr_w_stop", stop_n - s0, 1);
    chk("static_outputs", bad_n, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_target_port.md
I2C_TARGET_PORT -- requirements
Module: i2c_target_port

Interface
REQ-001 Parameter SHALL be: SLAVE_ADDR, default 7'h50, the 7-bit target address matched on the bus.
REQ-002 Port SHALL be: clk  input  1  the single system clock.
REQ-003 Port SHALL be: rst  input  1  asynchronous, active-high reset.
REQ-004 Port SHALL be: scl_i  input  1  raw SCL bus level.
REQ-005 Port SHALL be: scl_o  output  1  SCL wired-AND contribution; constant 1 (no clock stretching).
REQ-006 Port SHALL be: scl_oe  output  1  SCL pull-low enable; constant 0.
REQ-007 Port SHALL be: sda_i  input  1  raw SDA bus level.
REQ-008 Port SHALL be: sda_o  output  1  SDA wired-AND contribution; always equal to ~sda_oe.
REQ-009 Port SHALL be: sda_oe  output  1  1 = pull SDA low, 0 = release.
REQ-010 Port SHALL be: wr_data  output  8  received write byte, valid while wr_valid is high.
REQ-011 Port SHALL be: wr_valid  output  1  one-cycle pulse per received write data byte.
REQ-012 Port SHALL be: wr_first  output  1  high with wr_valid for the first data byte after the address.
REQ-013 Port SHALL be: wr_ready  input  1  back-end can accept a byte; selects ACK or NACK.
REQ-014 Port SHALL be: rd_req  output  1  one-cycle pulse requesting the next read byte.
REQ-015 Port SHALL be: rd_data  input  8  read byte, sampled the cycle after rd_req.
REQ-016 Port SHALL be: busy  output  1  high from address match until STOP, repeated START or reset.
REQ-017 Port SHALL be: stop  output  1  one-cycle pulse on STOP while busy.

Function
REQ-018 scl_i and sda_i SHALL each pass a 2-flop synchronizer. Edge detection SHALL use the synchronized levels only.
REQ-019 START SHALL be detected as a falling edge of synchronized SDA while synchronized SCL is high. STOP SHALL be detected as a rising edge under the same condition.
REQ-020 START SHALL be honoured in every state and SHALL enter ADDR with the bit counter cleared; this covers repeated START.
REQ-021 STOP SHALL force IDLE and release SDA from any state.
REQ-022 States SHALL be IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and WAIT_STOP.
REQ-023 Received bits SHALL be sampled MSB first on each synchronized SCL rising edge. SDA SHALL change only on the cycle after a synchronized SCL falling edge is detected.
REQ-024 On the 8th address bit: if addr[7:1] == SLAVE_ADDR, the block SHALL go to ADDR_ACK and assert busy; otherwise it SHALL go to WAIT_STOP with SDA released.
REQ-025 In ADDR_ACK: pull SDA low at the next falling edge; release it at the following falling edge.
REQ-026 After ADDR_ACK, the next state SHALL be WR_DATA if R/W = 0, or RD_DATA if R/W = 1.
REQ-027 On the 8th write-data rising edge: wr_data shall carry the byte and wr_valid shall pulse 1 cycle later. wr_first shall be high only for the first byte since the address.
REQ-028 ACK for a write byte SHALL be driven in WR_ACK only if wr_ready was high on the 8th rising edge; otherwise the block SHALL NACK and go to WAIT_STOP.
REQ-029 rd_req SHALL pulse on the cycle R/W = 1 is sampled in a matched address, and on each master ACK (SDA = 0) sampled in RD_ACK.
REQ-030 rd_data SHALL be loaded into the transmit shift register the cycle after rd_req.
REQ-031 In RD_DATA: drive each bit at the falling edge (sda_oe = ~bit); release SDA after the 8th bit's falling edge; enter RD_ACK.
REQ-032 In RD_ACK: master NACK (SDA = 1) SHALL go to WAIT_STOP, SDA released, with no rd_req.
REQ-033 General call (address 0x00) SHALL be treated as an address mismatch.
REQ-034 stop SHALL pulse 1 cycle after STOP detection only if busy was high.

Reset
REQ-035 On rst = 1, asynchronously: state = IDLE, sda_oe = 0, sda_o = 1, scl_oe = 0, scl_o = 1.
REQ-036 On rst = 1, asynchronously: wr_valid, wr_first, rd_req, busy and stop = 0; wr_data = 0.
REQ-037 On rst = 1, synchronizer flops SHALL be set to 1 (idle bus).
REQ-038 Reset mid-transfer SHALL release SDA immediately. After reset, the block SHALL ignore the bus until the next START.

Verification
REQ-039 START, 0xA0, 0x01, 0x23, 0x5A, STOP with wr_ready = 1 -> four ACKs; wr_valid with 0x01 (wr_first = 1), 0x23, 0x5A; one stop pulse.
REQ-040 START, 0xA4 (address 0x52) -> SDA never pulled low; no wr_valid; busy stays 0; no stop pulse.
REQ-041 START, 0xA1, rd_data = 0xC3, master NACK -> one rd_req; SDA bits 1,1,0,0,0,0,1,1; WAIT_STOP.
REQ-042 START, 0xA0, 0x10, repeated START, 0xA1, ACK then NACK with rd_data = 0x5A then 0x5B -> bytes 0x5A, 0x5B returned; two rd_req pulses.
REQ-043 START, 0xA0, 0x77 with wr_ready = 0 -> wr_valid pulses; 9th bit NACK (SDA high); the next byte is ignored.
REQ-044 rst asserted during the 3rd bit of a read byte -> sda_oe = 0 the same cycle; busy = 0; a subsequent write transaction completes normally.
